cache_ctrl_param: RTL and testbench
===================================

Name: cache_ctrl_param

Overview:
- Parametrised successor of the pipeline's direct-mapped write-back cache controller FSM.
- Sequences hit writes, dirty-block write-back and block refill against a word-serial memory port using MReq/MReady.
- Block size is generic: one word counter replaces the per-word state chain.
- Sits between the pipeline's cache datapath (tag/data arrays, offset mux) and the memory model; Stall freezes the pipeline.

Parameters:
- WORDS_PER_BLOCK, 4, words per cache block; power of two, >=2.
- OFFSET_W, $clog2(WORDS_PER_BLOCK), width of BlockOffset and the word counter (derived, not overridden).
- STAT_W, 32, width of statistics counters (optional feature only).

Ports:
- CLK  in  1  clock, rising edge.
- ResetN  in  1  synchronous, active-low reset.
- En  in  1  pipeline is issuing a cache access this cycle.
- Suspense  in  1  pipeline held by a hazard; do not commit a hit write.
- CWE  in  1  access is a store.
- Hit  in  1  tag match and valid, from datapath.
- Dirty  in  1  indexed line is dirty.
- MReady  in  1  memory completes current word transfer this cycle.
- WE  out  1  cache data-array write enable.
- SetValid  out  1  write valid bit of indexed line.
- SetDirty  out  1  value written to dirty bit when WE=1.
- MWE  out  1  memory write (write-back) request qualifier.
- MReq  out  1  memory word transfer request.
- BlockOffset  out  OFFSET_W  word index for write-back/refill transfer.
- OffsetSW  out  1  1 selects CPU address offset; 0 selects BlockOffset.
- Init  out  1  FSM idle and En high.
- Stall  out  1  pipeline must hold.
- State  out  2  current state encoding, for debug.

Behaviour:
- States (2-bit): IDLE=0, WB=1, RF=2, DONE=3. Word counter cnt, OFFSET_W bits.
- Reset (ResetN=0 at a clock edge): state=IDLE, cnt=0. Applies mid-transfer: the transaction is abandoned and MReq drops the next cycle.
- All outputs are driven to defined values every cycle (no x); unspecified controls are 0.
- IDLE:
  - OffsetSW=1.
  - En & Hit & CWE & ~Suspense: WE=1, SetValid=1, SetDirty=1 (same cycle, zero latency).
  - En & ~Hit: go to WB if Dirty, else RF; cnt=0.
  - Otherwise stay.
- WB:
  - MReq=1, MWE=1, BlockOffset=cnt, WE=0.
  - MReady: cnt++. On MReady with cnt==WORDS_PER_BLOCK-1: go to RF, cnt wraps to 0.
  - No MReady: hold state, cnt and outputs.
- RF:
  - MReq=1, MWE=0, BlockOffset=cnt.
  - MReady: WE=1, SetDirty=0, cnt++. On the last word also SetValid=1 and go to DONE, cnt wraps to 0.
  - WE=0 without MReady.
- DONE:
  - OffsetSW=1.
  - Suspense | ~En: stay, no writes.
  - Otherwise go to IDLE. If Hit & CWE in that cycle, perform the hit write (WE=SetValid=SetDirty=1), so the missed store commits exactly once.
- Stall = (state==WB) | (state==RF) | (state==IDLE & En & ~Hit).
- Init = (state==IDLE) & En.
- MReady is ignored in IDLE and DONE.
- Miss latency with MReady held high: clean miss = 1 + N cycles to DONE; dirty miss = 1 + 2N.

Optional Feature:
- Macro CACHE_CTRL_STATS_EN.
- When defined, adds outputs HitCount and MissCount, STAT_W bits each, reset to 0.
  - HitCount increments in IDLE on En & Hit & ~Suspense.
  - MissCount increments on every IDLE->WB or IDLE->RF transition.
  - Both counters wrap modulo 2^STAT_W.
- When undefined, neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - state encoding constants IDLE/WB/RF/DONE;
  - default WORDS_PER_BLOCK;
  - a function computing OFFSET_W.
- One sub-module, cache_word_counter: OFFSET_W-bit counter with clear, enable and last-word flag. It is used for cnt.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset: drive ResetN=0 during RF with cnt=2, then release -> State=0, MReq=0, WE=0, Stall=0 the next cycle.
- Store hit: En=1, Hit=1, CWE=1, Suspense=0 in IDLE -> WE=SetValid=SetDirty=1 the same cycle. Repeat with Suspense=1 -> WE=0.
- Clean load miss, N=4, MReady always 1 -> RF for 4 cycles, BlockOffset 0,1,2,3, WE=1 each, SetValid=1 only at offset 3, then DONE, then IDLE.
- Dirty store miss with MReady toggling every other cycle -> WB holds BlockOffset until each MReady, MWE=1 for 4 transfers, then RF. In DONE with Hit=1, CWE=1, Suspense=0 -> one write with SetDirty=1.
- Parameter sweep WORDS_PER_BLOCK=2 and 8 -> counter wraps at 1/7, clean-miss latency 3/9 cycles, BlockOffset width 1/3.
- With CACHE_CTRL_STATS_EN defined: 3 hits then 2 misses -> HitCount=3, MissCount=2. Preset MissCount to all-ones via a forced miss run -> wraps to 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the parametrised write-back cache controller:
// state encoding, default block size and offset-width helper.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WB   = 2'd1,
      RF   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int DEFAULT_WORDS_PER_BLOCK = 4;

   function automatic int offset_width(input int words);
      return (words <= 2) ? 1 : $clog2(words);
   endfunction

endpackage

// File: rtl/cache_word_counter.sv
// Word counter for block transfers; wraps naturally because the block size
// is a power of two, so the last word is the all-ones count.
module cache_word_counter
   #(parameter int WIDTH = 2)
   (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             last
   );

   always_ff @(posedge clk) begin
      if (!reset_n || clear)
         count <= '0;
      else if (enable)
         count <= count + 1'b1;
   end

   assign last = &count;

endmodule

// File: rtl/cache_ctrl_param.sv
// Direct-mapped write-back cache controller with a generic block size.
// Optional hit/miss statistics are enabled with CACHE_CTRL_STATS_EN.
module cache_ctrl_param
   import cache_pkg::*;
   #(
`ifdef CACHE_CTRL_STATS_EN
   parameter int STAT_W = 32,
`endif
   parameter int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
   localparam int OFFSET_W = offset_width(WORDS_PER_BLOCK)
   )
   (
   input  logic                CLK,
   input  logic                ResetN,
   input  logic                En,
   input  logic                Suspense,
   input  logic                CWE,
   input  logic                Hit,
   input  logic                Dirty,
   input  logic                MReady,
   output logic                WE,
   output logic                SetValid,
   output logic                SetDirty,
   output logic                MWE,
   output logic                MReq,
   output logic [OFFSET_W-1:0] BlockOffset,
   output logic                OffsetSW,
   output logic                Init,
   output logic                Stall,
`ifdef CACHE_CTRL_STATS_EN
   output logic [STAT_W-1:0]   HitCount,
   output logic [STAT_W-1:0]   MissCount,
`endif
   output logic [1:0]          State
   );

   state_t              state;
   state_t              state_next;
   logic [OFFSET_W-1:0] cnt;
   logic                cnt_last;
   logic                cnt_clear;
   logic                cnt_en;

   cache_word_counter #(.WIDTH(OFFSET_W)) u_word_counter (
      .clk     (CLK),
      .reset_n (ResetN),
      .clear   (cnt_clear),
      .enable  (cnt_en),
      .count   (cnt),
      .last    (cnt_last)
   );

   always_ff @(posedge CLK) begin
      if (!ResetN)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      WE         = 1'b0;
      SetValid   = 1'b0;
      SetDirty   = 1'b0;
      MWE        = 1'b0;
      MReq       = 1'b0;
      OffsetSW   = 1'b0;
      Init       = 1'b0;
      Stall      = 1'b0;
      cnt_clear  = 1'b0;
      cnt_en     = 1'b0;
      case (state)
         IDLE: begin
            OffsetSW  = 1'b1;
            Init      = En;
            cnt_clear = 1'b1;
            if (En && Hit && CWE && !Suspense) begin
               WE       = 1'b1;
               SetValid = 1'b1;
               SetDirty = 1'b1;
            end
            if (En && !Hit) begin
               Stall      = 1'b1;
               state_next = Dirty ? WB : RF;
            end
         end
         WB: begin
            MReq   = 1'b1;
            MWE    = 1'b1;
            Stall  = 1'b1;
            cnt_en = MReady;
            if (MReady && cnt_last)
               state_next = RF;
         end
         RF: begin
            MReq  = 1'b1;
            Stall = 1'b1;
            if (MReady) begin
               WE     = 1'b1;
               cnt_en = 1'b1;
               if (cnt_last) begin
                  SetValid   = 1'b1;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            OffsetSW  = 1'b1;
            cnt_clear = 1'b1;
            // The store that missed commits here, exactly once, on leaving DONE.
            if (En && !Suspense) begin
               state_next = IDLE;
               if (Hit && CWE) begin
                  WE       = 1'b1;
                  SetValid = 1'b1;
                  SetDirty = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign BlockOffset = cnt;
   assign State       = state;

`ifdef CACHE_CTRL_STATS_EN
   logic hit_evt;
   logic miss_evt;

   assign hit_evt  = (state == IDLE) && En && Hit && !Suspense;
   assign miss_evt = (state == IDLE) && En && !Hit;

   always_ff @(posedge CLK) begin
      if (!ResetN) begin
         HitCount  <= '0;
         MissCount <= '0;
      end else begin
         if (hit_evt)
            HitCount <= HitCount + 1'b1;
         if (miss_evt)
            MissCount <= MissCount + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Bench for cache_ctrl_param: table of per-cycle vectors for N=4, a block-size
// sweep over N=2/4/8, and statistics checks when CACHE_CTRL_STATS_EN is set.
module tb_cache_ctrl_param;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic rstn, en, sus, cwe, hit, dirty, mrdy;

   logic       we, sv, sd, mwe, mreq, osw, init, stall;
   logic [1:0] bo, st;

   logic [7:0] o2, o8;
   logic [0:0] bo2;
   logic [2:0] bo8;
   logic [1:0] st2, st8;

   int total = 0;
   int bad   = 0;

`ifdef CACHE_CTRL_STATS_EN
   logic [31:0] hc, mc, hc2, mc2, hc8, mc8;
   logic [1:0]  hcw, mcw;
   logic [7:0]  ow;
   logic [1:0]  bow, stw;
`endif

   cache_ctrl_param #(.WORDS_PER_BLOCK(4)) dut (
      .CLK(CLK), .ResetN(rstn), .En(en), .Suspense(sus), .CWE(cwe), .Hit(hit),
      .Dirty(dirty), .MReady(mrdy), .WE(we), .SetValid(sv), .SetDirty(sd),
      .MWE(mwe), .MReq(mreq), .BlockOffset(bo), .OffsetSW(osw), .Init(init),
      .Stall(stall),
`ifdef CACHE_CTRL_STATS_EN
      .HitCount(hc), .MissCount(mc),
`endif
      .State(st)
   );

   cache_ctrl_param #(.WORDS_PER_BLOCK(2)) dut2 (
      .CLK(CLK), .ResetN(rstn), .En(en), .Suspense(sus), .CWE(cwe), .Hit(hit),
      .Dirty(dirty), .MReady(mrdy), .WE(o2[0]), .SetValid(o2[1]), .SetDirty(o2[2]),
      .MWE(o2[3]), .MReq(o2[4]), .BlockOffset(bo2), .OffsetSW(o2[5]), .Init(o2[6]),
      .Stall(o2[7]),
`ifdef CACHE_CTRL_STATS_EN
      .HitCount(hc2), .MissCount(mc2),
`endif
      .State(st2)
   );

   cache_ctrl_param #(.WORDS_PER_BLOCK(8)) dut8 (
      .CLK(CLK), .ResetN(rstn), .En(en), .Suspense(sus), .CWE(cwe), .Hit(hit),
      .Dirty(dirty), .MReady(mrdy), .WE(o8[0]), .SetValid(o8[1]), .SetDirty(o8[2]),
      .MWE(o8[3]), .MReq(o8[4]), .BlockOffset(bo8), .OffsetSW(o8[5]), .Init(o8[6]),
      .Stall(o8[7]),
`ifdef CACHE_CTRL_STATS_EN
      .HitCount(hc8), .MissCount(mc8),
`endif
      .State(st8)
   );

`ifdef CACHE_CTRL_STATS_EN
   cache_ctrl_param #(.STAT_W(2), .WORDS_PER_BLOCK(4)) dut_w (
      .CLK(CLK), .ResetN(rstn), .En(en), .Suspense(sus), .CWE(cwe), .Hit(hit),
      .Dirty(dirty), .MReady(mrdy), .WE(ow[0]), .SetValid(ow[1]), .SetDirty(ow[2]),
      .MWE(ow[3]), .MReq(ow[4]), .BlockOffset(bow), .OffsetSW(ow[5]), .Init(ow[6]),
      .Stall(ow[7]), .HitCount(hcw), .MissCount(mcw), .State(stw)
   );
`endif

   // in = {rstn,en,sus,cwe,hit,dirty,mrdy}; wr = {we,sv,sd,mwe,mreq}; misc = {osw,init,stall}
   typedef struct {
      string      name;
      logic [6:0] in;
      logic [1:0] st;
      logic [4:0] wr;
      logic [1:0] bo;
      logic [2:0] misc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(string n, logic [6:0] i, logic [1:0] s, logic [4:0] w,
                               logic [1:0] b, logic [2:0] m);
      vec_t v;
      v.name = n; v.in = i; v.st = s; v.wr = w; v.bo = b; v.misc = m;
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic drv(input logic r, input logic e, input logic s, input logic c,
                      input logic h, input logic d, input logic m);
      @(negedge CLK);
      rstn = r; en = e; sus = s; cwe = c; hit = h; dirty = d; mrdy = m;
   endtask

   task automatic miss_run();
      drv(1, 1, 0, 0, 0, 0, 1);
      repeat (4) drv(1, 1, 0, 0, 0, 0, 1);
      drv(1, 1, 0, 0, 1, 0, 0);
      drv(1, 0, 0, 0, 0, 0, 0);
   endtask

   int lat[3];
   int off[3];

   initial begin
      rstn = 0; en = 0; sus = 0; cwe = 0; hit = 0; dirty = 0; mrdy = 0;

      tbl.push_back(mk("reset",       7'b0_000000, 2'd0, 5'b00000, 2'd0, 3'b100));
      tbl.push_back(mk("idle",        7'b1_000000, 2'd0, 5'b00000, 2'd0, 3'b100));
      tbl.push_back(mk("store_hit",   7'b1_101100, 2'd0, 5'b11100, 2'd0, 3'b110));
      tbl.push_back(mk("hit_susp",    7'b1_111100, 2'd0, 5'b00000, 2'd0, 3'b110));
      tbl.push_back(mk("load_hit",    7'b1_100100, 2'd0, 5'b00000, 2'd0, 3'b110));
      tbl.push_back(mk("clean_miss",  7'b1_100001, 2'd0, 5'b00000, 2'd0, 3'b111));
      tbl.push_back(mk("rf_w0",       7'b1_100001, 2'd2, 5'b10001, 2'd0, 3'b001));
      tbl.push_back(mk("rf_w1",       7'b1_100001, 2'd2, 5'b10001, 2'd1, 3'b001));
      tbl.push_back(mk("rf_w2",       7'b1_100001, 2'd2, 5'b10001, 2'd2, 3'b001));
      tbl.push_back(mk("rf_w3",       7'b1_100001, 2'd2, 5'b11001, 2'd3, 3'b001));
      tbl.push_back(mk("done_load",   7'b1_100100, 2'd3, 5'b00000, 2'd0, 3'b100));
      tbl.push_back(mk("idle_mrdy",   7'b1_000001, 2'd0, 5'b00000, 2'd0, 3'b100));
      tbl.push_back(mk("dirty_miss",  7'b1_101010, 2'd0, 5'b00000, 2'd0, 3'b111));
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk($sformatf("wb_%0d", k), {6'b1_10101, k[0]}, 2'd1, 5'b00011,
                          2'(k / 2), 3'b001));
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk($sformatf("rf_%0d", k), {6'b1_10101, k[0]}, 2'd2,
                          {k[0], (k == 7) ? 1'b1 : 1'b0, 3'b001}, 2'(k / 2), 3'b001));
      tbl.push_back(mk("done_susp",   7'b1_111100, 2'd3, 5'b00000, 2'd0, 3'b100));
      tbl.push_back(mk("done_noen",   7'b1_001100, 2'd3, 5'b00000, 2'd0, 3'b100));
      tbl.push_back(mk("done_commit", 7'b1_101100, 2'd3, 5'b11100, 2'd0, 3'b100));
      tbl.push_back(mk("once_only",   7'b1_000000, 2'd0, 5'b00000, 2'd0, 3'b100));
      tbl.push_back(mk("miss2",       7'b1_100001, 2'd0, 5'b00000, 2'd0, 3'b111));
      tbl.push_back(mk("miss2_w0",    7'b1_100001, 2'd2, 5'b10001, 2'd0, 3'b001));
      tbl.push_back(mk("miss2_w1",    7'b1_100001, 2'd2, 5'b10001, 2'd1, 3'b001));
      tbl.push_back(mk("rst_in_rf",   7'b0_100000, 2'd2, 5'b00001, 2'd2, 3'b001));
      tbl.push_back(mk("post_rst",    7'b1_000000, 2'd0, 5'b00000, 2'd0, 3'b100));
      tbl.push_back(mk("miss3",       7'b1_100000, 2'd0, 5'b00000, 2'd0, 3'b111));
      tbl.push_back(mk("cnt_cleared", 7'b1_100000, 2'd2, 5'b00001, 2'd0, 3'b001));
      tbl.push_back(mk("rst_again",   7'b0_000000, 2'd2, 5'b00001, 2'd0, 3'b001));
      tbl.push_back(mk("idle_end",    7'b1_000000, 2'd0, 5'b00000, 2'd0, 3'b100));

      foreach (tbl[i]) begin
         drv(tbl[i].in[6], tbl[i].in[5], tbl[i].in[4], tbl[i].in[3],
             tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
         #1;
         chk(tbl[i].name, {18'd0, st, we, sv, sd, mwe, mreq, bo, osw, init, stall},
             {18'd0, tbl[i].st, tbl[i].wr, tbl[i].bo, tbl[i].misc});
      end

      // Block-size sweep: all three instances take the same clean miss.
      for (int d = 0; d < 3; d++) begin
         lat[d] = -1;
         off[d] = -1;
      end
      drv(1, 1, 0, 0, 0, 0, 1);
      #1;
      for (int k = 0; k < 12; k++) begin
         if (lat[0] < 0 && st2 == 2'd3) lat[0] = k;
         if (lat[1] < 0 && st  == 2'd3) lat[1] = k;
         if (lat[2] < 0 && st8 == 2'd3) lat[2] = k;
         if (off[0] < 0 && st2 == 2'd2 && o2[1]) off[0] = int'(bo2);
         if (off[1] < 0 && st  == 2'd2 && sv)    off[1] = int'(bo);
         if (off[2] < 0 && st8 == 2'd2 && o8[1]) off[2] = int'(bo8);
         @(negedge CLK);
         #1;
      end
      chk("lat_n2", lat[0], 3);
      chk("lat_n4", lat[1], 5);
      chk("lat_n8", lat[2], 9);
      chk("last_off_n2", off[0], 1);
      chk("last_off_n4", off[1], 3);
      chk("last_off_n8", off[2], 7);
      drv(0, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 0, 0);
      #1;
      chk("sweep_rst_n2", {30'd0, st2}, 0);
      chk("sweep_rst_n8", {30'd0, st8}, 0);

`ifdef CACHE_CTRL_STATS_EN
      chk("stat_rst_hit", hc, 0);
      chk("stat_rst_miss", mc, 0);
      drv(1, 1, 0, 1, 1, 0, 0);
      drv(1, 1, 0, 0, 1, 0, 0);
      drv(1, 1, 1, 1, 1, 0, 0);
      drv(1, 1, 0, 1, 1, 0, 0);
      drv(1, 0, 0, 0, 0, 0, 0);
      miss_run();
      miss_run();
      #1;
      chk("hit_count", hc, 3);
      chk("miss_count", mc, 2);
      chk("hit_count_w", {30'd0, hcw}, 3);
      chk("miss_count_w", {30'd0, mcw}, 2);
      miss_run();
      miss_run();
      #1;
      chk("miss_count4", mc, 4);
      chk("miss_wrap", {30'd0, mcw}, 0);
      chk("hit_hold", hc, 3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
